// File: rtl/game_pkg.sv
// Shared types and constants for the symbol-counting game controller and its display path.
// Holds the state encoding, field widths and the default period durations.
package game_pkg;

  localparam int LEVEL_W = 5;
  localparam int SEC_W   = 6;

  localparam int PRELIM_SEC_DEF = 3;
  localparam int GAME_SEC_DEF   = 20;
  localparam int ANSWER_SEC_DEF = 10;
  localparam int POST_SEC_DEF   = 3;
  localparam int MAX_LEVEL_DEF  = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRELIM = 3'd1,
    ST_GAME   = 3'd2,
    ST_ANSWER = 3'd3,
    ST_POST   = 3'd4,
    ST_OVER   = 3'd5
  } game_state_t;

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter; decrements on tick, saturates at 0, load has priority.
// expire is combinational so the owner can reload on the same edge the count runs out.
module sec_countdown
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SEC_W-1:0] loadVal,
  input  logic             tick,
  output logic [SEC_W-1:0] count,
  output logic             expire
);

  logic [SEC_W-1:0] count_q;
  logic [SEC_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = loadVal;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - SEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == SEC_W'(1));

endmodule

// File: rtl/game_phase_sequencer.sv
// Game controller: sequences PRELIM/GAME/ANSWER/POST periods off the 1 Hz pulse and advances the level.
// Every output is a flop or a decode of the registered state; the seconds counter is reloaded on each transition.
module game_phase_sequencer
  import game_pkg::*;
#(
  parameter int PRELIM_SEC = PRELIM_SEC_DEF,
  parameter int GAME_SEC   = GAME_SEC_DEF,
  parameter int ANSWER_SEC = ANSWER_SEC_DEF,
  parameter int POST_SEC   = POST_SEC_DEF,
  parameter int MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input  logic               Clk100M,
  input  logic               reset,
  input  logic               tick1Hz,
  input  logic               start,
  input  logic               answerDone,
  input  logic               answerCorrect,
  output logic               prelimPeriod,
  output logic               gamePeriod,
  output logic               answerPeriod,
  output logic               postPeriod,
  output logic               levelChng,
  output logic [LEVEL_W-1:0] level,
  output logic [SEC_W-1:0]   secondsLeft,
  output logic               lastCorrect,
  output logic               gameOver,
  output logic               gameWon
);

  game_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               last_q, last_d;
  logic               won_q, won_d;
  logic               over_q, over_d;
  logic               chg_q, chg_d;

  logic               cnt_load;
  logic [SEC_W-1:0]   cnt_load_val;
  logic [SEC_W-1:0]   cnt_count;
  logic               cnt_expire;

  sec_countdown u_sec_countdown (
    .clk     (Clk100M),
    .rst_n   (reset),
    .load    (cnt_load),
    .loadVal (cnt_load_val),
    .tick    (tick1Hz),
    .count   (cnt_count),
    .expire  (cnt_expire)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    last_d       = last_q;
    won_d        = won_q;
    chg_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d      = ST_PRELIM;
          level_d      = LEVEL_W'(1);
          won_d        = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = SEC_W'(PRELIM_SEC);
        end
      end
      ST_PRELIM: begin
        if (cnt_expire) begin
          state_d      = ST_GAME;
          cnt_load     = 1'b1;
          cnt_load_val = SEC_W'(GAME_SEC);
        end
      end
      ST_GAME: begin
        if (cnt_expire) begin
          state_d      = ST_ANSWER;
          cnt_load     = 1'b1;
          cnt_load_val = SEC_W'(ANSWER_SEC);
        end
      end
      ST_ANSWER: begin
        // A submission on the expiring tick still counts as answered.
        if (answerDone || cnt_expire) begin
          state_d      = ST_POST;
          last_d       = answerDone && answerCorrect;
          cnt_load     = 1'b1;
          cnt_load_val = SEC_W'(POST_SEC);
        end
      end
      ST_POST: begin
        if (cnt_expire) begin
          cnt_load = 1'b1;
          if (last_q && (level_q < LEVEL_W'(MAX_LEVEL))) begin
            state_d      = ST_PRELIM;
            level_d      = level_q + LEVEL_W'(1);
            chg_d        = 1'b1;
            cnt_load_val = SEC_W'(PRELIM_SEC);
          end else begin
            state_d = ST_OVER;
            won_d   = last_q;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_load = 1'b1;
      end
    endcase
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge Clk100M or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      last_q  <= 1'b0;
      won_q   <= 1'b0;
      over_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      last_q  <= last_d;
      won_q   <= won_d;
      over_q  <= over_d;
      chg_q   <= chg_d;
    end
  end

  assign prelimPeriod = (state_q == ST_PRELIM);
  assign gamePeriod   = (state_q == ST_GAME);
  assign answerPeriod = (state_q == ST_ANSWER);
  assign postPeriod   = (state_q == ST_POST);
  assign levelChng    = chg_q;
  assign level        = level_q;
  assign secondsLeft  = cnt_count;
  assign lastCorrect  = last_q;
  assign gameOver     = over_q;
  assign gameWon      = won_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Randomized bench for game_phase_sequencer, checked every cycle against a phase/level/seconds reference model.
module tb_game_phase_sequencer;
  import game_pkg::*;

  localparam int PRE  = 3;
  localparam int GAM  = 20;
  localparam int ANS  = 10;
  localparam int PST  = 3;
  localparam int MAXL = 2;

  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_GAME = 2;
  localparam int M_ANS  = 3;
  localparam int M_POST = 4;
  localparam int M_OVER = 5;

  logic Clk100M = 1'b0;
  logic reset = 1'b0;
  logic tick1Hz = 1'b0;
  logic start = 1'b0;
  logic answerDone = 1'b0;
  logic answerCorrect = 1'b0;
  logic prelimPeriod, gamePeriod, answerPeriod, postPeriod, levelChng;
  logic [LEVEL_W-1:0] level;
  logic [SEC_W-1:0]   secondsLeft;
  logic lastCorrect, gameOver, gameWon;

  game_phase_sequencer #(
    .PRELIM_SEC (PRE),
    .GAME_SEC   (GAM),
    .ANSWER_SEC (ANS),
    .POST_SEC   (PST),
    .MAX_LEVEL  (MAXL)
  ) dut (
    .Clk100M       (Clk100M),
    .reset         (reset),
    .tick1Hz       (tick1Hz),
    .start         (start),
    .answerDone    (answerDone),
    .answerCorrect (answerCorrect),
    .prelimPeriod  (prelimPeriod),
    .gamePeriod    (gamePeriod),
    .answerPeriod  (answerPeriod),
    .postPeriod    (postPeriod),
    .levelChng     (levelChng),
    .level         (level),
    .secondsLeft   (secondsLeft),
    .lastCorrect   (lastCorrect),
    .gameOver      (gameOver),
    .gameWon       (gameWon)
  );

  always #5 Clk100M = ~Clk100M;

  int m_ph, m_level, m_secs;
  bit m_last, m_won, m_chg;
  int n_chk = 0;
  int n_pass = 0;
  int n_wins = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_level = 0; m_secs = 0;
    m_last = 0; m_won = 0; m_chg = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input bit ad, input bit ac);
    m_chg = 0;
    if (m_ph == M_IDLE || m_ph == M_OVER) begin
      if (st) begin
        m_ph = M_PRE; m_level = 1; m_won = 0; m_secs = PRE;
      end
    end else if (m_ph == M_ANS && ad) begin
      m_last = ac; m_ph = M_POST; m_secs = PST;
    end else if (tk) begin
      if (m_secs > 1) m_secs--;
      else if (m_ph == M_PRE) begin m_ph = M_GAME; m_secs = GAM; end
      else if (m_ph == M_GAME) begin m_ph = M_ANS; m_secs = ANS; end
      else if (m_ph == M_ANS) begin m_last = 0; m_ph = M_POST; m_secs = PST; end
      else if (m_last && m_level < MAXL) begin
        m_level++; m_chg = 1; m_ph = M_PRE; m_secs = PRE;
      end else begin
        m_ph = M_OVER; m_won = m_last; m_secs = 0;
        if (m_last) n_wins++;
      end
    end
  endtask

  task automatic compare_all();
    chk("prelimPeriod", prelimPeriod, int'(m_ph == M_PRE));
    chk("gamePeriod",   gamePeriod,   int'(m_ph == M_GAME));
    chk("answerPeriod", answerPeriod, int'(m_ph == M_ANS));
    chk("postPeriod",   postPeriod,   int'(m_ph == M_POST));
    chk("levelChng",    levelChng,    int'(m_chg));
    chk("level",        level,        m_level);
    chk("secondsLeft",  secondsLeft,  m_secs);
    chk("lastCorrect",  lastCorrect,  int'(m_last));
    chk("gameOver",     gameOver,     int'(m_ph == M_OVER));
    chk("gameWon",      gameWon,      int'(m_won));
  endtask

  initial begin
    bit st, tk, ad, ac, did_rst;
    did_rst = 0;
    model_reset();
    repeat (3) @(negedge Clk100M);
    compare_all();
    reset = 1'b1;

    // Ticks with no start must leave the block idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk100M);
      compare_all();
      tick1Hz = 1'b1;
      model_step(0, 1, 0, 0);
      @(negedge Clk100M);
      compare_all();
      tick1Hz = 1'b0;
    end

    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge Clk100M);
      compare_all();
      if (!did_rst && m_ph == M_GAME && m_secs == 12) begin
        did_rst = 1;
        tick1Hz = 0; start = 0; answerDone = 0; answerCorrect = 0;
        reset = 1'b0;
        #1;
        chk("async_gamePeriod", gamePeriod, 0);
        chk("async_level", level, 0);
        chk("async_secondsLeft", secondsLeft, 0);
        model_reset();
        @(negedge Clk100M);
        compare_all();
        reset = 1'b1;
        continue;
      end
      st = ($urandom % 30 == 0) || (m_ph == M_GAME && $urandom % 8 == 0);
      tk = ($urandom % 3 == 0);
      ad = ($urandom % 40 == 0);
      ac = ($urandom % 4 != 0);
      if (m_ph == M_ANS && m_secs == 7 && $urandom % 6 == 0) begin ad = 1; ac = 1; end
      if (m_ph == M_ANS && m_secs == 1 && $urandom % 2 == 0) begin tk = 1; ad = 1; ac = 1; end
      start = st; tick1Hz = tk; answerDone = ad; answerCorrect = ac;
      model_step(st, tk, ad, ac);
    end
    @(negedge Clk100M);
    compare_all();
    chk("mid_game_reset_hit", int'(did_rst), 1);
    chk("won_game_seen", int'(n_wins > 0), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
